// File: rtl/pulse_stretcher_pkg.sv
// tow_pkg: shared FSM encoding, default pulse timing and counter sizing helper
// Ports: none (package). Used by pulse_stretcher and pulse_stretcher_if.
package tow_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_GAP = 2'd2} state_t;
   localparam int DEF_HOLD_CYC = 4;
   localparam int DEF_GAP_CYC = 2;
   localparam int DEF_PEND_W = 3;
   function automatic int cnt_width(input int hold_cyc, input int gap_cyc);
      int m;
      m = hold_cyc > gap_cyc ? hold_cyc : gap_cyc;
      return m <= 1 ? 1 : $clog2(m);
   endfunction
endpackage

// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if: strobe in, stretched level and queue status out
// Ports: strobe (event), lvl_out (level), busy, pend[PEND_W] (queued strobes), ovf (sticky loss)
// master drives strobe (producer side), slave is the stretcher.
interface pulse_stretcher_if import tow_pkg::*; #(parameter int PEND_W = DEF_PEND_W);
   logic strobe;
   logic lvl_out;
   logic busy;
   logic [PEND_W-1:0] pend;
   logic ovf;
   modport master(output strobe, input lvl_out, busy, pend, ovf);
   modport slave(input strobe, output lvl_out, busy, pend, ovf);
endinterface

// File: rtl/pulse_stretcher_cnt.sv
// stretch_cnt: loadable down-counter that parks at zero and flags it
// Ports: clk, rst, load, load_val[W], dec, zero
module stretch_cnt #(parameter int W = 2) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
   always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
   assign zero = cnt_q == '0;
endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches one-cycle strobes into HOLD_CYC-wide pulses separated by GAP_CYC low cycles
// Ports: clk, rst (sync, active-high), bus (pulse_stretcher_if.slave: strobe in; lvl_out, busy, pend, ovf out)
// Macro PULSE_STRETCHER_RETRIG_EN: a strobe during HOLD extends the current pulse instead of queueing.
module pulse_stretcher import tow_pkg::*; #(
   parameter int HOLD_CYC = DEF_HOLD_CYC,
   parameter int GAP_CYC  = DEF_GAP_CYC,
   parameter int PEND_W   = DEF_PEND_W
) (
   input logic clk,
   input logic rst,
   pulse_stretcher_if.slave bus
);
   localparam int CW = cnt_width(HOLD_CYC, GAP_CYC);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   state_t state_q, state_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic ovf_q, ovf_d;
   logic load, zero, pend_dec, q_inc, retrig;
   logic [CW-1:0] load_val;
   stretch_cnt #(.W(CW)) u_cnt (
      .clk(clk),
      .rst(rst),
      .load(load),
      .load_val(load_val),
      .dec(state_q != ST_IDLE),
      .zero(zero)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pend_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q <= pend_d;
         ovf_q <= ovf_d;
      end
   end
   always_comb begin
      state_d = state_q;
      load = 1'b0;
      load_val = HOLD_LD;
      pend_dec = 1'b0;
      retrig = 1'b0;
      case (state_q)
         ST_IDLE: if (bus.strobe) begin
            state_d = ST_HOLD;
            load = 1'b1;
         end
         ST_HOLD:
`ifdef PULSE_STRETCHER_RETRIG_EN
            if (bus.strobe) begin
               load = 1'b1;
               retrig = 1'b1;
            end else
`endif
            if (zero) begin
               state_d = ST_GAP;
               load = 1'b1;
               load_val = GAP_LD;
            end
         ST_GAP: if (zero) begin
            if (pend_q != '0) begin
               state_d = ST_HOLD;
               load = 1'b1;
               pend_dec = 1'b1;
            end else state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   // a queued strobe coinciding with a replay start cancels out: no change, no overflow
   always_comb begin
      q_inc = bus.strobe && state_q != ST_IDLE && !retrig;
      pend_d = (q_inc == pend_dec) ? pend_q :
               q_inc ? (pend_q == PEND_MAX ? pend_q : pend_q + PEND_W'(1)) : pend_q - PEND_W'(1);
      ovf_d = ovf_q || (q_inc && !pend_dec && pend_q == PEND_MAX);
   end
   always_comb begin
      bus.lvl_out = state_q == ST_HOLD;
      bus.busy = state_q != ST_IDLE;
      bus.pend = pend_q;
      bus.ovf = ovf_q;
   end
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: schedule-based reference model, per-cycle compare, literal timing pins, random stimulus
module tb_pulse_stretcher;
   localparam int H = 4;
   localparam int G = 2;
   localparam int PMAX = 7;
   localparam int LOGN = 8192;
`ifdef PULSE_STRETCHER_RETRIG_EN
   localparam bit RETRIG = 1'b1;
`else
   localparam bit RETRIG = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int base = 0;
   bit chk_en = 1'b0;
   bit m_act = 1'b0;
   int m_start = 0;
   int m_endh = 0;
   int m_pend = 0;
   bit m_ovf = 1'b0;
   bit lg_lvl[LOGN];
   bit lg_busy[LOGN];
   bit lg_ovf[LOGN];
   int lg_pend[LOGN];
   pulse_stretcher_if #(.PEND_W(3)) bus ();
   pulse_stretcher #(.HOLD_CYC(H), .GAP_CYC(G), .PEND_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic bit m_hi(input int c);
      return m_act && c >= m_start && c <= m_endh;
   endfunction
   function automatic bit m_busy(input int c);
      return m_act && c >= m_start && c <= m_endh + G;
   endfunction
   // Pulse occupies cycles [start, endh], then G low cycles; a strobe sampled in cycle c acts from c+1.
   task automatic model_step(input bit s);
      int c;
      bit hi, ex, dec, q;
      c = cyc;
      if (rst) begin
         m_act = 1'b0;
         m_pend = 0;
         m_ovf = 1'b0;
      end else if (!m_act) begin
         if (s) begin
            m_act = 1'b1;
            m_start = c + 1;
            m_endh = c + H;
         end
      end else begin
         hi = c <= m_endh;
         ex = c == m_endh + G;
         dec = ex && m_pend > 0;
         q = s && !(RETRIG && hi);
         if (RETRIG && s && hi) m_endh = c + H;
         if (q && !dec) begin
            if (m_pend == PMAX) m_ovf = 1'b1;
            else m_pend++;
         end else if (dec && !q) m_pend--;
         if (ex) begin
            if (dec) begin
               m_start = c + 1;
               m_endh = c + H;
            end else m_act = 1'b0;
         end
      end
      cyc = c + 1;
   endtask
   task automatic tick(input bit s);
      bus.strobe = s;
      @(posedge clk);
      model_step(s);
      #1;
   endtask
   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
      end
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick(1'b0);
      tick(1'b0);
      rst = 1'b0;
      base = cyc;
   endtask
   task automatic run_to(input int n);
      while (cyc < base + n) tick(1'b0);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1);
   end
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         if (cyc < LOGN) begin
            lg_lvl[cyc] = bus.lvl_out;
            lg_busy[cyc] = bus.busy;
            lg_ovf[cyc] = bus.ovf;
            lg_pend[cyc] = int'(bus.pend);
         end
         chk("lvl_out", int'(bus.lvl_out), int'(m_hi(cyc)));
         chk("busy", int'(bus.busy), int'(m_busy(cyc)));
         chk("pend", int'(bus.pend), m_pend);
         chk("ovf", int'(bus.ovf), int'(m_ovf));
      end
   end
   initial begin
      int dens;
      int r;
      bus.strobe = 1'b0;
      do_reset();
      chk_en = 1'b1;
      tick(1'b0);
      chk("rst_lvl", int'(lg_lvl[base + 1]), 0);
      chk("rst_busy", int'(lg_busy[base + 1]), 0);
      chk("rst_pend", lg_pend[base + 1], 0);
      chk("rst_ovf", int'(lg_ovf[base + 1]), 0);
      // single strobe: high 11..14, busy through 16, idle at 17
      do_reset();
      run_to(10);
      tick(1'b1);
      run_to(25);
      chk("s1_lvl10", int'(lg_lvl[base + 10]), 0);
      chk("s1_lvl11", int'(lg_lvl[base + 11]), 1);
      chk("s1_lvl14", int'(lg_lvl[base + 14]), 1);
      chk("s1_lvl15", int'(lg_lvl[base + 15]), 0);
      chk("s1_busy16", int'(lg_busy[base + 16]), 1);
      chk("s1_busy17", int'(lg_busy[base + 17]), 0);
      // strobes at 10, 12 and on the GAP-exit cycle 16
      do_reset();
      run_to(10);
      tick(1'b1);
      tick(1'b0);
      tick(1'b1);
      run_to(16);
      tick(1'b1);
      run_to(35);
`ifndef PULSE_STRETCHER_RETRIG_EN
      chk("s2_pend13", lg_pend[base + 13], 1);
      chk("s2_pend16", lg_pend[base + 16], 1);
      chk("s4_pend17", lg_pend[base + 17], 1);
      chk("s2_lvl16", int'(lg_lvl[base + 16]), 0);
      chk("s2_lvl17", int'(lg_lvl[base + 17]), 1);
      chk("s2_lvl20", int'(lg_lvl[base + 20]), 1);
      chk("s2_lvl21", int'(lg_lvl[base + 21]), 0);
      chk("s4_lvl23", int'(lg_lvl[base + 23]), 1);
      chk("s4_pend23", lg_pend[base + 23], 0);
      chk("s4_ovf23", int'(lg_ovf[base + 23]), 0);
`endif
      // strobe every cycle 10..20: saturation and sticky overflow
      do_reset();
      run_to(10);
      repeat (11) tick(1'b1);
`ifndef PULSE_STRETCHER_RETRIG_EN
      run_to(80);
      chk("s3_pend19", lg_pend[base + 19], 7);
      chk("s3_ovf19", int'(lg_ovf[base + 19]), 0);
      chk("s3_ovf20", int'(lg_ovf[base + 20]), 1);
      chk("s3_ovf70", int'(lg_ovf[base + 70]), 1);
      chk("s3_busy70", int'(lg_busy[base + 70]), 0);
`endif
      // reset mid-HOLD after a saturating burst, then normal timing again
      do_reset();
      run_to(10);
      repeat (11) tick(1'b1);
      r = 0;
      while (!m_hi(cyc) && r < 100) begin
         tick(1'b0);
         r++;
      end
      chk("s5_in_hold", int'(bus.lvl_out), 1);
      rst = 1'b1;
      tick(1'b0);
      rst = 1'b0;
      r = cyc;
      tick(1'b0);
      chk("s5_lvl", int'(lg_lvl[r]), 0);
      chk("s5_busy", int'(lg_busy[r]), 0);
      chk("s5_pend", lg_pend[r], 0);
      chk("s5_ovf", int'(lg_ovf[r]), 0);
      base = r;
      run_to(10);
      tick(1'b1);
      run_to(20);
      chk("s5_lvl11", int'(lg_lvl[base + 11]), 1);
      chk("s5_lvl14", int'(lg_lvl[base + 14]), 1);
      chk("s5_lvl15", int'(lg_lvl[base + 15]), 0);
      // strobes at 10 and 13
      do_reset();
      run_to(10);
      tick(1'b1);
      run_to(13);
      tick(1'b1);
      run_to(30);
`ifdef PULSE_STRETCHER_RETRIG_EN
      chk("s6_pend14", lg_pend[base + 14], 0);
      chk("s6_lvl17", int'(lg_lvl[base + 17]), 1);
      chk("s6_lvl18", int'(lg_lvl[base + 18]), 0);
      chk("s6_busy19", int'(lg_busy[base + 19]), 1);
      chk("s6_busy20", int'(lg_busy[base + 20]), 0);
`else
      chk("s6_pend14", lg_pend[base + 14], 1);
      chk("s6_lvl15", int'(lg_lvl[base + 15]), 0);
      chk("s6_lvl17", int'(lg_lvl[base + 17]), 1);
      chk("s6_pend17", lg_pend[base + 17], 0);
`endif
      dens = 30;
      for (int i = 0; i < 4000; i++) begin
         if (i % 200 == 0) dens = $urandom_range(0, 3) == 0 ? 5 : $urandom_range(0, 2) == 0 ? 95 : $urandom_range(20, 70);
         rst = $urandom_range(0, 599) == 0;
         tick($urandom_range(0, 99) < dens);
      end
      rst = 1'b0;
      repeat (80) tick(1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
